// File: rtl/fcvt_int2fp_pipe.sv
// Three-stage integer-to-IEEE-754 converter: capture/negate, normalise, round/pack.
// A single advance enable stalls the whole pipe when the output is held.
module fcvt_int2fp_pipe #(
    parameter int XLEN  = 64,
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_data,
    input  logic                   in_signed,
    input  logic [2:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_fp,
    output logic                   out_nx
);

    localparam int IDX_W  = $clog2(XLEN);
    localparam int EXT_W  = XLEN + MAN_W + 2;
    localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0] BIAS = BIAS_I[EXP_W-1:0];

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage 1 combinational: sign and magnitude of the operand.
    logic            w_s1_sign;
    logic [XLEN-1:0] w_s1_mag;
    rm_e             w_s1_rm;
    assign w_s1_sign = in_signed & in_data[XLEN-1];
    assign w_s1_mag  = w_s1_sign ? ({XLEN{1'b0}} - in_data) : in_data;
    assign w_s1_rm   = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);

    logic            r_v1;
    logic            r1_sign;
    logic [XLEN-1:0] r1_mag;
    rm_e             r1_rm;

    // Stage 2 combinational: leading-one search, normalise, split frac/G/St.
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_shamt;
    logic [XLEN-2:0]  w_norm_lo;
    logic [EXT_W-1:0] w_ext;
    logic [MAN_W-1:0] w_frac;
    logic             w_g;
    logic             w_st;

    // NOTE: the loop overwrites w_idx in ascending order, so the last hit (the
    // highest set bit) wins; the default assignment first keeps this latch-free.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (r1_mag[i]) w_idx = IDX_W'(i);
        end
    end

    assign w_shamt   = IDX_W'(XLEN - 1) - w_idx;
    assign w_norm_lo = (XLEN-1)'(r1_mag << w_shamt);
    assign w_ext     = {w_norm_lo, {(MAN_W + 3){1'b0}}};
    assign w_frac    = w_ext[EXT_W-1 -: MAN_W];
    assign w_g       = w_ext[EXT_W-1-MAN_W];
    assign w_st      = |w_ext[EXT_W-2-MAN_W:0];

    logic             r_v2;
    logic             r2_sign;
    logic             r2_zero;
    rm_e              r2_rm;
    logic [IDX_W-1:0] r2_idx;
    logic [MAN_W-1:0] r2_frac;
    logic             r2_g;
    logic             r2_st;

    // Stage 3 combinational: rounding increment, mantissa carry into exponent.
    logic                   w_inc;
    logic [MAN_W:0]         w_sum;
    logic [EXP_W-1:0]       w_exp;
    logic [EXP_W+MAN_W:0]   w_fp;
    logic                   w_nx;

    always_comb begin
        case (r2_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r2_sign & (r2_g | r2_st);
            RM_RUP:  w_inc = !r2_sign & (r2_g | r2_st);
            RM_RMM:  w_inc = r2_g;
            default: w_inc = r2_g & (r2_st | r2_frac[0]);
        endcase
    end

    assign w_sum = {1'b0, r2_frac} + (MAN_W+1)'(w_inc);
    assign w_exp = EXP_W'(r2_idx) + BIAS + EXP_W'(w_sum[MAN_W]);
    assign w_fp  = r2_zero ? '0 : {r2_sign, w_exp, w_sum[MAN_W-1:0]};
    assign w_nx  = !r2_zero && (r2_g || r2_st);

    // Control and output registers; only these carry reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
            out_fp    <= '0;
            out_nx    <= 1'b0;
        end else if (w_adv) begin
            r_v1      <= in_valid;
            r_v2      <= r_v1;
            out_valid <= r_v2;
            if (r_v2) begin
                out_fp <= w_fp;
                out_nx <= w_nx;
            end
        end
    end

    // NOTE: datapath registers have no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_sign <= w_s1_sign;
            r1_mag  <= w_s1_mag;
            r1_rm   <= w_s1_rm;
            r2_sign <= r1_sign;
            r2_zero <= (r1_mag == '0);
            r2_rm   <= r1_rm;
            r2_idx  <= w_idx;
            r2_frac <= w_frac;
            r2_g    <= w_g;
            r2_st   <= w_st;
        end
    end

endmodule

// File: tb/tb_fcvt_int2fp_pipe.sv
// Bench for fcvt_int2fp_pipe (binary64): directed vectors, stall, reset flush and
// a randomised scoreboarded stream against a remainder-based rounding model.
module tb_fcvt_int2fp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_signed;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_fp;
    logic        out_nx;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [63:0] data; logic sgn; logic [2:0] rm; } op_t;
    typedef struct { logic [63:0] fp; logic nx; } exp_t;

    op_t  op_q[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fcvt_int2fp_pipe #(.XLEN(64), .EXP_W(11), .MAN_W(52)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .out_nx    (out_nx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient/remainder against the half-ulp point.
    function automatic exp_t ref_cvt(input logic [63:0] d, input logic sgn, input logic [2:0] rm);
        exp_t        r;
        logic        neg;
        logic [63:0] mag, q, rem, half;
        logic        up;
        int          e, sh;
        neg = sgn && d[63];
        mag = neg ? (64'd0 - d) : d;
        r.fp = 64'd0;
        r.nx = 1'b0;
        if (mag == 64'd0) return r;
        e = 0;
        while ((mag >> e) > 64'd1) e++;
        if (e <= 52) begin
            q = mag << (52 - e);
        end else begin
            sh   = e - 52;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            r.nx = (rem != 64'd0);
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = neg && (rem != 64'd0);
                3'd3:    up = !neg && (rem != 64'd0);
                3'd4:    up = (rem >= half);
                default: up = (rem > half) || (rem == half && q[0]);
            endcase
            q = q + 64'(up);
            if (q == (64'd1 << 53)) begin
                q = q >> 1;
                e++;
            end
        end
        r.fp = {neg, 11'(e + 1023), q[51:0]};
        return r;
    endfunction

    function automatic logic [63:0] rand_data();
        int k;
        k = $urandom_range(1, 62);
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 1000));
            2: return 64'd1 << k;
            3: return (64'd1 << k) + (($urandom_range(0, 1) != 0) ? 64'd1 : 64'hFFFF_FFFF_FFFF_FFFF);
            4: begin
                case ($urandom_range(0, 2))
                    0: return 64'd0;
                    1: return 64'hFFFF_FFFF_FFFF_FFFF;
                    default: return 64'h8000_0000_0000_0000;
                endcase
            end
            default: return {$urandom, $urandom} >> k;
        endcase
    endfunction

    // Single operand with out_ready high: checks latency and result.
    task automatic run_one(input string tag, input logic [63:0] d, input logic sgn,
                           input logic [2:0] rm, input logic [63:0] exp_fp, input logic exp_nx);
        int cycles;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = sgn;
        in_rm     = rm;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cycles   = 1;
        while (!out_valid && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'd3);
        check({tag, "_fp"}, out_fp, exp_fp);
        check({tag, "_nx"}, 64'(out_nx), 64'(exp_nx));
    endtask

    // mode 0: all operands offered back to back, out_ready low on cycles 3 and 4.
    // mode 1: random input bubbles and random out_ready.
    task automatic run_stream(input int mode);
        int   issued = 0;
        int   received = 0;
        int   c = 0;
        int   n;
        exp_t e;
        n = op_q.size();
        exp_q.delete();
        while ((issued < n || exp_q.size() != 0) && c < 5000) begin
            @(negedge clk);
            if (issued < n && (mode == 0 || $urandom_range(0, 4) != 0)) begin
                in_valid  = 1'b1;
                in_data   = op_q[issued].data;
                in_signed = op_q[issued].sgn;
                in_rm     = op_q[issued].rm;
            end else begin
                in_valid = 1'b0;
            end
            if (mode == 0) out_ready = !(c == 3 || c == 4);
            else           out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("stream_fp", out_fp, e.fp);
                    check("stream_nx", 64'(out_nx), 64'(e.nx));
                    received++;
                end else begin
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_hold_fp", out_fp, exp_q[0].fp);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_cvt(op_q[issued].data, op_q[issued].sgn, op_q[issued].rm));
                issued++;
            end
            c++;
        end
        check("stream_count", 64'(received), 64'(n));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int stale;
        op_t o;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'd5;
        in_signed = 1'b0;
        in_rm     = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_fp", out_fp, 64'd0);
        check("rst_out_nx", 64'(out_nx), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        stale    = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_override_in_valid", 64'(stale), 64'd0);

        run_one("one_rne",      64'd1,                   1'b0, 3'd0, 64'h3FF0_0000_0000_0000, 1'b0);
        run_one("m1_signed",    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 64'hBFF0_0000_0000_0000, 1'b0);
        run_one("zero_rdn",     64'd0,                   1'b1, 3'd2, 64'h0000_0000_0000_0000, 1'b0);
        run_one("p53_rne",      (64'd1 << 53) + 64'd1,   1'b0, 3'd0, 64'h4340_0000_0000_0000, 1'b1);
        run_one("p53_rup",      (64'd1 << 53) + 64'd1,   1'b0, 3'd3, 64'h4340_0000_0000_0001, 1'b1);
        run_one("max_u_rne",    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 64'h43F0_0000_0000_0000, 1'b1);
        run_one("max_u_rtz",    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd1, 64'h43EF_FFFF_FFFF_FFFF, 1'b1);
        run_one("min_s",        64'h8000_0000_0000_0000, 1'b1, 3'd0, 64'hC3E0_0000_0000_0000, 1'b0);
        run_one("rm7_as_rne",   (64'd1 << 53) + 64'd3,   1'b0, 3'd7, 64'h4340_0000_0000_0002, 1'b1);
        run_one("neg_rdn",      64'd0 - ((64'd1 << 53) + 64'd1), 1'b1, 3'd2, 64'hC340_0000_0000_0001, 1'b1);

        op_q.delete();
        o.data = 64'd1;                   o.sgn = 1'b0; o.rm = 3'd0; op_q.push_back(o);
        o.data = 64'hFFFF_FFFF_FFFF_FFFF; o.sgn = 1'b1; o.rm = 3'd0; op_q.push_back(o);
        o.data = (64'd1 << 53) + 64'd1;   o.sgn = 1'b0; o.rm = 3'd3; op_q.push_back(o);
        o.data = 64'h8000_0000_0000_0000; o.sgn = 1'b1; o.rm = 3'd4; op_q.push_back(o);
        run_stream(0);

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = rand_data();
            in_signed = 1'b0;
            in_rm     = 3'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_fp", out_fp, 64'd0);
        check("flush_out_nx", 64'(out_nx), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        stale     = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("flush_no_stale", 64'(stale), 64'd0);

        op_q.delete();
        for (int k = 0; k < 300; k++) begin
            o.data = rand_data();
            o.sgn  = 1'($urandom_range(0, 1));
            o.rm   = 3'($urandom_range(0, 7));
            op_q.push_back(o);
        end
        run_stream(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
